uart_debug_in: RTL

Debug command input path. It receives ASCII hex over a UART RX pin (8N1) and assembles 4 hex digits terminated by CR or LF into a 16-bit word. It presents that word with a one-cycle valid strobe, e.g. to load a value into the EEPROM/config path. The block is self-contained: it contains a bit-level receiver with mid-bit sampling, plus a line-parser FSM.

---
 rtl/uart_debug_in.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_debug_in.sv
// Debug command input: 8N1 UART receiver with mid-bit sampling feeding a
// line parser that turns "XXXX<CR|LF>" hex lines into a 16-bit word.
module uart_debug_in #(
  parameter int CLK_FREQ  = 20,
  parameter int UART_BAUD = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        parse_err
);

  localparam int DIV  = (CLK_FREQ * 1000000) / UART_BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;

  logic          rx_meta, rx_sync;
  logic [1:0]    fill;
  logic          armed;

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    rx_shift, shift_n;
  logic          byte_stb, stop_bad;

  logic          is_hex, is_term;
  logic [3:0]    nib;
  logic [15:0]   pshift;
  logic [2:0]    pcount;
  logic          perr_flag;

  // Arming waits until the synchronizer holds real samples (not its reset
  // value), so a line held low across reset release never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      fill    <= '0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && rx_sync) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      rx_shift <= shift_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    bit_n    = bit_idx;
    shift_n  = rx_shift;
    byte_stb = 1'b0;
    stop_bad = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (armed && !rx_sync) state_n = S_START;
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == DIV_M1) begin
          cnt_n   = '0;
          shift_n = {rx_sync, rx_shift[7:1]};
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == DIV_M1) begin
          cnt_n = '0;
          if (rx_sync) begin
            byte_stb = 1'b1;
            state_n  = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_sync) state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    is_hex  = 1'b0;
    nib     = '0;
    is_term = (rx_shift == 8'h0D) || (rx_shift == 8'h0A);
    if (rx_shift >= 8'h30 && rx_shift <= 8'h39) begin
      is_hex = 1'b1;
      nib    = 4'(rx_shift - 8'h30);
    end else if (rx_shift >= 8'h41 && rx_shift <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(rx_shift - 8'h37);
    end else if (rx_shift >= 8'h61 && rx_shift <= 8'h66) begin
      is_hex = 1'b1;
      nib    = 4'(rx_shift - 8'h57);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parse_err  <= 1'b0;
      pshift     <= '0;
      pcount     <= '0;
      perr_flag  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parse_err  <= 1'b0;
      frame_err  <= stop_bad;
      if (stop_bad) begin
        perr_flag <= 1'b1;
      end else if (byte_stb) begin
        if (is_term) begin
          if (!perr_flag && pcount == 3'd4) begin
            data       <= pshift;
            data_valid <= 1'b1;
          end else if (perr_flag || pcount != 3'd0) begin
            parse_err <= 1'b1;
          end
          pshift    <= '0;
          pcount    <= '0;
          perr_flag <= 1'b0;
        end else if (!is_hex) begin
          perr_flag <= 1'b1;
        end else if (!perr_flag) begin
          if (pcount == 3'd4) begin
            perr_flag <= 1'b1;
          end else begin
            pshift <= {pshift[11:0], nib};
            pcount <= pcount + 1'b1;
          end
        end
      end
    end
  end

endmodule
